// File: rtl/seg_scan_if.sv
// Display-side bundle for the 7-segment scanner: scan strobe, frame data in,
// anode/segment drives and frame status out.
interface seg_scan_if #(
   parameter int DIGITS = 8
);
   localparam int IW = $clog2(DIGITS);

   logic                  scan_in;
   logic                  en;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp;
   logic [DIGITS-1:0]     digit_en;
   logic [DIGITS-1:0]     an;
   logic [6:0]            seg;
   logic                  seg_dp;
   logic [IW-1:0]         digit_idx;
   logic                  frame_done;

   modport master (
      output scan_in, en, data, dp, digit_en,
      input  an, seg, seg_dp, digit_idx, frame_done
   );

   modport slave (
      input  scan_in, en, data, dp, digit_en,
      output an, seg, seg_dp, digit_idx, frame_done
   );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scanner: steps one digit per scan strobe rise,
// shows a per-frame shadow of the data and blanks briefly after each step.
module seg_scan #(
   parameter int DIGITS         = 8,
   parameter int BLANK_CYCLES   = 2,
   parameter int ACTIVE_LOW_AN  = 1,
   parameter int ACTIVE_LOW_SEG = 1
) (
   input logic        clk,
   input logic        rst,
   seg_scan_if.slave  bus
);
   localparam int IW = $clog2(DIGITS);
   localparam int BW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
   localparam logic AN_POL  = (ACTIVE_LOW_AN != 0);
   localparam logic SEG_POL = (ACTIVE_LOW_SEG != 0);
   localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_POL}};
   localparam logic [6:0]        SEG_OFF = {7{SEG_POL}};
   localparam logic [IW-1:0]     LAST    = IW'(DIGITS - 1);

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic                scan_q;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow_data;
   logic [DIGITS-1:0]   shadow_dp;
   logic [BW-1:0]       blank_cnt;
   logic                loaded;
   logic                frame_done_q;
   logic [DIGITS-1:0]   an_q;
   logic [6:0]          seg_q;
   logic                seg_dp_q;

   logic rise, step, wrap, blank;
   logic [DIGITS-1:0] onehot;
   logic [3:0]        nib;

   always_comb begin
      rise   = bus.scan_in & ~scan_q;
      step   = rise & bus.en;
      wrap   = step & (idx == LAST);
      blank  = (blank_cnt != '0) | ~bus.en | ~bus.digit_en[idx];
      onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
      nib    = shadow_data[{idx, 2'b00} +: 4];
   end

   // Scan state: strobe edge detect, digit index, shadow frame and blanking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_q       <= 1'b1;
         idx          <= '0;
         shadow_data  <= '0;
         shadow_dp    <= '0;
         blank_cnt    <= BW'(BLANK_CYCLES);
         loaded       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         scan_q       <= bus.scan_in;
         frame_done_q <= wrap;
         if (bus.en) begin
            if (step) begin
               idx       <= wrap ? '0 : idx + IW'(1);
               blank_cnt <= BW'(BLANK_CYCLES);
            end else if (blank_cnt != '0) begin
               blank_cnt <= blank_cnt - BW'(1);
            end
            // The new frame's shadow is captured on the same edge as the step
            // so digit 0 already shows it.
            if (wrap || (step && !loaded)) begin
               shadow_data <= bus.data;
               shadow_dp   <= bus.dp;
               loaded      <= 1'b1;
            end
         end
      end
   end

   // Output register: drives computed from pre-edge state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_q     <= AN_OFF;
         seg_q    <= SEG_OFF;
         seg_dp_q <= SEG_POL;
      end else if (blank) begin
         an_q     <= AN_OFF;
         seg_q    <= SEG_OFF;
         seg_dp_q <= SEG_POL;
      end else begin
         an_q     <= onehot ^ AN_OFF;
         seg_q    <= hex_to_seg(nib) ^ SEG_OFF;
         seg_dp_q <= shadow_dp[idx] ^ SEG_POL;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.seg_dp     = seg_dp_q;
   assign bus.digit_idx  = idx;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at default parameters (8 digits, 2 blank cycles,
// active-low anodes and segments).
module tb_seg_scan;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   // Active-low 7-segment patterns (gfedcba inverted) for nibbles 0..F
   logic [6:0] seg_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_if #(.DIGITS(8)) bus ();

   seg_scan #(
      .DIGITS(8), .BLANK_CYCLES(2), .ACTIVE_LOW_AN(1), .ACTIVE_LOW_SEG(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] an_for(input int i);
      logic [7:0] oh;
      oh = 8'h01 << i;
      return ~oh;
   endfunction

   // One divider period of 4 clocks: rise, two blank slots, then the driven digit
   task automatic step(input logic [2:0] ei, input logic [7:0] ean, input logic [6:0] eseg,
                       input logic edp, input logic efd);
      bus.scan_in = 1'b1;
      tick();
      check_vec("idx", bus.digit_idx, ei);
      check_vec("frame_done", bus.frame_done, efd);
      bus.scan_in = 1'b0;
      tick();
      check_vec("frame_done_clr", bus.frame_done, 0);
      check_vec("blank1_an", bus.an, 8'hFF);
      tick();
      check_vec("blank2_seg", bus.seg, 7'h7F);
      tick();
      check_vec("an", bus.an, ean);
      check_vec("seg", bus.seg, eseg);
      check_vec("seg_dp", bus.seg_dp, edp);
   endtask

   initial begin
      bus.scan_in  = 1'b1;
      bus.en       = 1'b0;
      bus.data     = '0;
      bus.dp       = '0;
      bus.digit_en = 8'h00;
      repeat (3) tick();
      check_vec("rst_idx", bus.digit_idx, 0);
      check_vec("rst_an", bus.an, 8'hFF);
      check_vec("rst_seg", bus.seg, 7'h7F);
      check_vec("rst_dp", bus.seg_dp, 1);
      check_vec("rst_fd", bus.frame_done, 0);

      // Strobe already high at release must not count as a step
      rst    = 1'b1;
      bus.en = 1'b1;
      repeat (10) tick();
      check_vec("hold_idx", bus.digit_idx, 0);
      check_vec("hold_an", bus.an, 8'hFF);
      check_vec("hold_seg", bus.seg, 7'h7F);

      bus.scan_in  = 1'b0;
      bus.digit_en = 8'hFF;
      bus.data     = 32'h76543210;
      repeat (3) tick();
      check_vec("preload_an", bus.an, 8'hFE);
      check_vec("preload_seg", bus.seg, seg_al[0]);

      // Frame A; data changes mid-frame must not tear
      for (int i = 1; i < 8; i++) begin
         step(3'(i), an_for(i), seg_al[i], 1'b1, 1'b0);
         if (i == 3) bus.data = 32'hFFFFFFFF;
      end
      step(3'd0, 8'hFE, 7'h0E, 1'b1, 1'b1);
      step(3'd1, 8'hFD, 7'h0E, 1'b1, 1'b0);

      bus.data     = 32'h000000B0;
      bus.dp       = 8'h03;
      bus.digit_en = 8'hFE;
      for (int i = 2; i < 8; i++) step(3'(i), an_for(i), 7'h0E, 1'b1, 1'b0);
      step(3'd0, 8'hFF, 7'h7F, 1'b1, 1'b1);
      step(3'd1, 8'hFD, seg_al[11], 1'b0, 1'b0);
      for (int i = 2; i < 6; i++) step(3'(i), an_for(i), seg_al[0], 1'b1, 1'b0);

      // Display disabled at idx 5 while the strobe keeps running
      bus.en = 1'b0;
      tick();
      check_vec("dis_an", bus.an, 8'hFF);
      check_vec("dis_seg", bus.seg, 7'h7F);
      for (int s = 0; s < 20; s++) begin
         bus.scan_in = 1'b1;
         tick();
         bus.scan_in = 1'b0;
         repeat (3) tick();
         check_vec("dis_idx", bus.digit_idx, 5);
         check_vec("dis_fd", bus.frame_done, 0);
      end
      bus.en = 1'b1;
      tick();
      check_vec("reen_an", bus.an, 8'hDF);
      check_vec("reen_seg", bus.seg, seg_al[0]);
      step(3'd6, 8'hBF, seg_al[0], 1'b1, 1'b0);

      // Asynchronous reset in the middle of a blank gap
      bus.data    = 32'h000000A0;
      bus.scan_in = 1'b1;
      tick();
      check_vec("pre_rst_idx", bus.digit_idx, 7);
      bus.scan_in = 1'b0;
      tick();
      #2 rst = 1'b0;
      #1;
      check_vec("async_idx", bus.digit_idx, 0);
      check_vec("async_an", bus.an, 8'hFF);
      check_vec("async_seg", bus.seg, 7'h7F);
      tick();
      rst = 1'b1;
      repeat (3) tick();
      check_vec("post_rst_an", bus.an, 8'hFF);
      step(3'd1, 8'hFD, seg_al[10], 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
